vc_plane_controller: RTL and testbench

- Time-division selector for virtual-channel (VC) planes at a network node.
- Emits the index of the currently active VC plane. The plane advances round-robin through 0..VC-1 and holds on each plane for a fixed number of cycles.
- Node injection/ejection logic uses the index to pick which per-VC data/valid pair drives the shared link and which VC ejected flits are booked to.
- Also provides a one-hot view of the active plane and a wrap pulse.

---
 rtl/vc_plane_controller_if.sv | 13 +
 rtl/vc_plane_controller.sv | 74 +++++++
 tb/tb_vc_plane_controller.sv | 130 +++++++++++++
 3 files changed

// File: rtl/vc_plane_controller_if.sv
// Output bundle of the VC plane selector: active index, one-hot view and rotation wrap pulse.
interface vc_plane_controller_if #(
    parameter int unsigned VC = 4
);
    localparam int unsigned SEL_W = $clog2(VC);

    logic [SEL_W-1:0] VCPlaneSelectorCFSM;
    logic [VC-1:0]    VCPlaneOneHot;
    logic             planeWrap;

    modport master (output VCPlaneSelectorCFSM, output VCPlaneOneHot, output planeWrap);
    modport slave  (input  VCPlaneSelectorCFSM, input  VCPlaneOneHot, input  planeWrap);
endinterface

// File: rtl/vc_plane_controller.sv
// Free-running time-division selector: dwells CYCLES_PER_PLANE cycles on each VC plane,
// rotating 0..VC-1, with a one-hot decode and a one-cycle pulse on each return to plane 0.
module vc_plane_controller #(
    parameter int unsigned VC               = 4,
    parameter int unsigned CYCLES_PER_PLANE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    vc_plane_controller_if.master vc_if
);
    localparam int unsigned SEL_W    = $clog2(VC);
    localparam int unsigned DWELL_RAW = $clog2(CYCLES_PER_PLANE + 1);
    localparam int unsigned DWELL_W  = (DWELL_RAW < 1) ? 1 : DWELL_RAW;

    localparam logic [SEL_W-1:0]   LAST_SEL   = SEL_W'(VC - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(CYCLES_PER_PLANE - 1);

    if (VC < 2 || VC > 256) begin : g_bad_vc
        $error("vc_plane_controller: VC must be in 2..256");
    end
    if (CYCLES_PER_PLANE < 1 || CYCLES_PER_PLANE > 65535) begin : g_bad_cpp
        $error("vc_plane_controller: CYCLES_PER_PLANE must be in 1..65535");
    end

    logic [SEL_W-1:0]   r_sel;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_wrap;

    logic [SEL_W-1:0]   w_sel_nxt;
    logic [DWELL_W-1:0] w_dwell_nxt;
    logic               w_wrap_nxt;
    logic [VC-1:0]      w_onehot;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sel   <= '0;
            r_dwell <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_sel   <= w_sel_nxt;
            r_dwell <= w_dwell_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    // Next state: count dwell, then advance the plane; explicit wrap at VC-1.
    always_comb begin
        w_sel_nxt   = r_sel;
        w_dwell_nxt = r_dwell + DWELL_W'(1);
        w_wrap_nxt  = 1'b0;
        if (r_dwell == DWELL_LAST) begin
            w_dwell_nxt = '0;
            if (r_sel == LAST_SEL) begin
                w_sel_nxt  = '0;
                w_wrap_nxt = 1'b1;
            end else begin
                w_sel_nxt = r_sel + SEL_W'(1);
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        for (int unsigned i = 0; i < VC; i++) begin
            w_onehot[i] = (r_sel == SEL_W'(i));
        end
    end

    assign vc_if.VCPlaneSelectorCFSM = r_sel;
    assign vc_if.VCPlaneOneHot       = w_onehot;
    assign vc_if.planeWrap           = r_wrap;

endmodule

// File: tb/tb_vc_plane_controller.sv
// Directed bench for vc_plane_controller across several VC / dwell configurations.
module tb_vc_plane_controller;

    logic       clk;
    logic [4:0] rst_v;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vc_plane_controller_if #(.VC(4)) if0 ();
    vc_plane_controller_if #(.VC(4)) if1 ();
    vc_plane_controller_if #(.VC(3)) if2 ();
    vc_plane_controller_if #(.VC(4)) if3 ();
    vc_plane_controller_if #(.VC(8)) if4 ();

    vc_plane_controller #(.VC(4), .CYCLES_PER_PLANE(1)) u_dut0 (.clk(clk), .rst(rst_v[0]), .vc_if(if0));
    vc_plane_controller #(.VC(4), .CYCLES_PER_PLANE(3)) u_dut1 (.clk(clk), .rst(rst_v[1]), .vc_if(if1));
    vc_plane_controller #(.VC(3), .CYCLES_PER_PLANE(1)) u_dut2 (.clk(clk), .rst(rst_v[2]), .vc_if(if2));
    vc_plane_controller #(.VC(4), .CYCLES_PER_PLANE(2)) u_dut3 (.clk(clk), .rst(rst_v[3]), .vc_if(if3));
    vc_plane_controller #(.VC(8), .CYCLES_PER_PLANE(5)) u_dut4 (.clk(clk), .rst(rst_v[4]), .vc_if(if4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // f: 0 = selector, 1 = one-hot, 2 = wrap pulse
    function automatic logic [31:0] probe(input int d, input int f);
        logic [31:0] v;
        v = '0;
        case (d)
            0: v = (f == 0) ? 32'(if0.VCPlaneSelectorCFSM) : (f == 1) ? 32'(if0.VCPlaneOneHot) : 32'(if0.planeWrap);
            1: v = (f == 0) ? 32'(if1.VCPlaneSelectorCFSM) : (f == 1) ? 32'(if1.VCPlaneOneHot) : 32'(if1.planeWrap);
            2: v = (f == 0) ? 32'(if2.VCPlaneSelectorCFSM) : (f == 1) ? 32'(if2.VCPlaneOneHot) : 32'(if2.planeWrap);
            3: v = (f == 0) ? 32'(if3.VCPlaneSelectorCFSM) : (f == 1) ? 32'(if3.VCPlaneOneHot) : 32'(if3.planeWrap);
            default: v = (f == 0) ? 32'(if4.VCPlaneSelectorCFSM) : (f == 1) ? 32'(if4.VCPlaneOneHot) : 32'(if4.planeWrap);
        endcase
        return v;
    endfunction

    // Check current outputs (at negedge), then move to the next negedge.
    task automatic expect_step(input int d, input int unsigned es, input int unsigned ew, input string tag);
        chk({tag, "_sel"},  probe(d, 0), 32'(es));
        chk({tag, "_oh"},   probe(d, 1), 32'(1) << es);
        chk({tag, "_wrap"}, probe(d, 2), 32'(ew));
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold reset for n edges checking reset outputs; returns at a negedge with reset released.
    task automatic do_reset(input int d, input int n, input string tag);
        rst_v[d] = 1'b0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_rst_sel"},  probe(d, 0), 32'd0);
            chk({tag, "_rst_oh"},   probe(d, 1), 32'd1);
            chk({tag, "_rst_wrap"}, probe(d, 2), 32'd0);
        end
        rst_v[d] = 1'b1;
    endtask

    int unsigned rr_sel   [6]  = '{0, 1, 2, 3, 0, 1};
    int unsigned rr_wrap  [6]  = '{0, 0, 0, 0, 1, 0};
    int unsigned dw_sel   [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    int unsigned mid_sel  [5]  = '{0, 0, 1, 1, 2};

    initial begin
        int unsigned wraps;
        int unsigned run_len;
        logic [31:0] prev_sel;
        logic [31:0] cur_sel;

        rst_v = '0;
        @(negedge clk);

        // Reset held 3 cycles, then round-robin with single-cycle dwell
        do_reset(0, 3, "rst4x1");
        for (int i = 0; i < 6; i++) expect_step(0, rr_sel[i], rr_wrap[i], "rr4x1");

        // Dwell of 3 cycles per plane
        do_reset(1, 1, "dw4x3");
        for (int i = 0; i < 13; i++) expect_step(1, dw_sel[i], (i == 12) ? 1 : 0, "dw4x3");

        // Non-power-of-two plane count
        do_reset(2, 1, "np3x1");
        for (int i = 0; i < 10; i++) expect_step(2, i % 3, (i > 0 && i % 3 == 0) ? 1 : 0, "np3x1");

        // Reset asserted mid-dwell on plane 2
        do_reset(3, 1, "mid4x2");
        for (int i = 0; i < 5; i++) expect_step(3, mid_sel[i], 0, "mid4x2_pre");
        chk("mid4x2_at2", probe(3, 0), 32'd2);
        rst_v[3] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_v[3] = 1'b1;
        expect_step(3, 0, 0, "mid4x2_post0");
        expect_step(3, 0, 0, "mid4x2_post1");
        expect_step(3, 1, 0, "mid4x2_post2");

        // Long run, 8 planes x 5 cycles
        do_reset(4, 1, "long8x5");
        wraps    = 0;
        run_len  = 0;
        prev_sel = '0;
        for (int k = 0; k < 1000; k++) begin
            cur_sel = probe(4, 0);
            if (probe(4, 2) == 32'd1) wraps++;
            if (k > 0 && cur_sel != prev_sel) begin
                chk("long8x5_run", 32'(run_len), 32'd5);
                run_len = 1;
            end else begin
                run_len++;
            end
            prev_sel = cur_sel;
            expect_step(4, (k / 5) % 8, (k > 0 && k % 40 == 0) ? 1 : 0, "long8x5");
        end
        chk("long8x5_wraps", 32'(wraps), 32'd24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
